// File: rtl/key_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package key_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        RELEASE  = 2'd3
    } key_state_e;

    localparam logic [3:0] COL_IDLE = 4'b1110;
    localparam logic [3:0] ROW_NONE = 4'hF;

    // Exactly one row low; ghosting patterns (two or more low) never count as a key.
    function automatic logic row_valid(input logic [3:0] rows);
        logic ok;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_digit(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles high (no key).
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex digit entry register.
//   state    | meaning
//   SCAN     | stepping columns, sample rows on last dwell cycle
//   DEBOUNCE | column frozen, counting cycles rows equal the latched pattern
//   ACCEPT   | single cycle after a debounced press; outputs already updated
//   RELEASE  | column frozen, counting cycles with all rows high
module key_scanner
    import key_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] KEY_R,
    output logic [3:0] KEY_C,
    output logic [7:0] out,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    rs;
    key_state_e    state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    kc_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [7:0]    out_q, out_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    key_sync #(.W(4)) u_sync (
        .clk (clk),
        .clr (clr),
        .d_i (KEY_R),
        .q_o (rs)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            kc_q    <= COL_IDLE;
            dwell_q <= '0;
            cnt_q   <= '0;
            pat_q   <= ROW_NONE;
            out_q   <= 8'h00;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            kc_q    <= ~(4'b0001 << col_d);
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_valid(rs)) begin
                        pat_d   = rs;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs != pat_q) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ACCEPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCEPT: begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (rs != ROW_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                dwell_d = '0;
                state_d = SCAN;
            end
        endcase
    end

    // Outputs load on the edge into ACCEPT so they are visible during the ACCEPT cycle.
    always_comb begin
        out_d   = out_q;
        code_d  = code_q;
        valid_d = 1'b0;
        if (state_q == DEBOUNCE && state_d == ACCEPT) begin
            code_d  = key_digit(row_index(pat_q), col_q);
            out_d   = {out_q[3:0], code_d};
            valid_d = 1'b1;
        end
    end

    assign KEY_C     = kc_q;
    assign out       = out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_key_scanner.sv
// Self-checking bench for key_scanner with a behavioural keypad and entry-value model.
module tb_key_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int LAT_MIN = DB + 3;
    localparam int LAT_MAX = 4 * SD + DB + 2;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] KEY_R;
    logic [3:0] KEY_C;
    logic [7:0] out;
    logic [3:0] key_code;
    logic       key_valid;

    logic [15:0] pressed   = '0;
    logic        bounce_hi = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;
    int   dbl_cnt = 0;
    logic prev_valid = 1'b0;
    int   exp_out = 0;

    key_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk       (clk),
        .clr       (clr),
        .KEY_R     (KEY_R),
        .KEY_C     (KEY_C),
        .out       (out),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        KEY_R = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !KEY_C[c]) KEY_R[r] = 1'b0;
        if (bounce_hi) KEY_R = 4'hF;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (key_valid) begin
            pulse_cnt++;
            if (prev_valid) dbl_cnt++;
        end
        prev_valid = key_valid;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #3;
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        prev_valid = 1'b0;
        exp_out = 0;
        repeat (4) step();
    endtask

    task automatic press_key(input int r, input int c, input int hold);
        int p0;
        int lat;
        bit got;
        p0 = pulse_cnt;
        lat = 0;
        got = 0;
        pressed = '0;
        pressed[r*4+c] = 1'b1;
        for (int i = 1; i <= 40 && !got; i++) begin
            step();
            if (pulse_cnt != p0) begin
                got = 1;
                lat = i;
            end
        end
        exp_out = ((exp_out << 4) | (r * 4 + c)) & 255;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL press_timeout key r%0d c%0d: no key_valid within 40 cycles", r, c);
        end else begin
            n_cmp++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
                n_err++;
                $display("FAIL press_latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
            end
            n_cmp++;
            if (key_code !== 4'(r * 4 + c)) begin
                n_err++;
                $display("FAIL key_code: got %h expected %h", key_code, 4'(r * 4 + c));
            end
            n_cmp++;
            if (out !== exp_out[7:0]) begin
                n_err++;
                $display("FAIL out_value: got %h expected %h", out, exp_out[7:0]);
            end
        end
        repeat (hold) step();
        n_cmp++;
        if (pulse_cnt != p0 + 1) begin
            n_err++;
            $display("FAIL hold_pulses: got %0d pulses expected 1", pulse_cnt - p0);
        end
        pressed = '0;
        repeat (20) step();
        n_cmp++;
        if (pulse_cnt != p0 + 1) begin
            n_err++;
            $display("FAIL release_pulses: got %0d pulses expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_c;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (KEY_C !== 4'b1110) begin n_err++; $display("FAIL reset_KEY_C: got %b expected 1110", KEY_C); end
        n_cmp++;
        if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h expected 00", out); end
        n_cmp++;
        if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        n_cmp++;
        if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        clr = 1'b1;
        for (int j = 0; j <= 33; j++) begin
            if (j > 0) step();
            exp_c = ~(4'b0001 << ((j / SD) % 4));
            n_cmp++;
            if (KEY_C !== exp_c) begin
                n_err++;
                $display("FAIL scan_column cycle %0d: got %b expected %b", j, KEY_C, exp_c);
            end
        end
        n_cmp++;
        if (pulse_cnt != 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt); end
    endtask

    task automatic test_single_key();
        logic [3:0] seen;
        press_key(1, 2, 200);
        seen = '0;
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            seen = seen | ~KEY_C;
        end
        n_cmp++;
        if (seen !== 4'hF) begin n_err++; $display("FAIL scan_resume: columns seen %b expected 1111", seen); end
    endtask

    task automatic test_sequence();
        pulse_clr();
        press_key(3, 3, 30);
        n_cmp++;
        if (out !== 8'h0F) begin n_err++; $display("FAIL seq_first: got %h expected 0f", out); end
        press_key(0, 1, 30);
        n_cmp++;
        if (out !== 8'hF1) begin n_err++; $display("FAIL seq_second: got %h expected f1", out); end
        press_key(2, 0, 30);
        n_cmp++;
        if (out !== 8'h18) begin n_err++; $display("FAIL seq_third: got %h expected 18", out); end
    endtask

    task automatic test_bounce();
        int p0;
        logic [3:0] seen;
        p0 = pulse_cnt;
        pressed = '0;
        pressed[2*4+1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bounce_hi = ((i / 3) % 2) == 1;
            step();
        end
        bounce_hi = 1'b0;
        pressed = '0;
        repeat (20) step();
        n_cmp++;
        if (pulse_cnt != p0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", pulse_cnt - p0); end
        seen = '0;
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            seen = seen | ~KEY_C;
        end
        n_cmp++;
        if (seen !== 4'hF) begin n_err++; $display("FAIL bounce_scan: columns seen %b expected 1111", seen); end
        press_key(2, 1, 40);
    endtask

    task automatic test_multi_row();
        int p0;
        int changes;
        logic [3:0] prev_c;
        p0 = pulse_cnt;
        changes = 0;
        pressed = '0;
        pressed[1*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        prev_c = KEY_C;
        for (int i = 0; i < 16 * SD; i++) begin
            step();
            if (KEY_C !== prev_c) changes++;
            prev_c = KEY_C;
        end
        pressed = '0;
        repeat (4) step();
        n_cmp++;
        if (pulse_cnt != p0) begin n_err++; $display("FAIL multi_row_pulses: got %0d expected 0", pulse_cnt - p0); end
        n_cmp++;
        if (changes != 16) begin n_err++; $display("FAIL multi_row_scan: got %0d column steps expected 16", changes); end
    endtask

    task automatic test_clr_release();
        int p0;
        bit got;
        pulse_clr();
        p0 = pulse_cnt;
        got = 0;
        pressed = '0;
        pressed[1*4+2] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (pulse_cnt != p0) got = 1;
        end
        exp_out = 6;
        n_cmp++;
        if (!got || out !== exp_out[7:0]) begin
            n_err++;
            $display("FAIL clr_first_press: got out %h expected %h (pulse seen %0d)", out, exp_out[7:0], got);
        end
        repeat (3) step();
        #2;
        clr = 1'b0;
        #1;
        n_cmp++;
        if (out !== 8'h00 || key_code !== 4'h0 || key_valid !== 1'b0 || KEY_C !== 4'b1110) begin
            n_err++;
            $display("FAIL clr_async: got out %h code %h valid %b cols %b expected 00 0 0 1110",
                     out, key_code, key_valid, KEY_C);
        end
        step();
        step();
        clr = 1'b1;
        prev_valid = 1'b0;
        exp_out = 6;
        n_cmp++;
        if (pulse_cnt != p0 + 1) begin n_err++; $display("FAIL clr_no_pulse: got %0d pulses expected 1", pulse_cnt - p0); end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (pulse_cnt != p0 + 1) got = 1;
        end
        n_cmp++;
        if (!got || out !== exp_out[7:0] || key_code !== 4'h6) begin
            n_err++;
            $display("FAIL clr_redetect: got out %h code %h expected 06 6 (pulse seen %0d)", out, key_code, got);
        end
        repeat (60) step();
        n_cmp++;
        if (pulse_cnt != p0 + 2) begin n_err++; $display("FAIL clr_held_pulses: got %0d expected 2", pulse_cnt - p0); end
        pressed = '0;
        repeat (20) step();
    endtask

    task automatic test_random();
        int r;
        int c;
        for (int k = 0; k < 8; k++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            press_key(r, c, int'($urandom_range(0, 50)));
            repeat (int'($urandom_range(0, 7))) step();
        end
    endtask

    task automatic test_back_to_back();
        n_cmp++;
        if (dbl_cnt != 0) begin n_err++; $display("FAIL back_to_back: got %0d consecutive pulses expected 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_multi_row();
        test_clr_release();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_scanner.md
# key_scanner

Upstream input stage for the register/PC datapath. Scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and decodes one hex digit per key press. It shifts each digit into an 8-bit entry value `out`, which drives the datapath's `key_out` data input. Exactly one `key_valid` pulse is issued per debounced press; auto-repeat is not supported.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each column is driven before advancing; must be ≥ 4.
- `DEBOUNCE_CNT`, 500000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `KEY_R`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `KEY_C`  out  4  keypad column drive, one-hot active-low.
- `out`  out  8  entry value: last two accepted digits, older digit in `[7:4]`.
- `key_code`  out  4  most recently accepted digit.
- `key_valid`  out  1  one-cycle pulse in the cycle `out`/`key_code` update.

## Operation
- Reset values: `KEY_C`=4'b1110 (column 0), `out`=8'h00, `key_code`=4'h0, `key_valid`=0, state SCAN, all counters 0.
- `KEY_R` passes through a 2-flop synchroniser; all logic uses the synchronised value `rs`.
- Column index c (0..3): `KEY_C` = ~(1<<c). Row index r = position of the single 0 bit in `rs`. Digit = {r[1:0], c[1:0]}, i.e. r*4+c.
- A row pattern is valid only when `rs` has exactly one bit low. All-high means no key. Two or more bits low counts as no key in every state.
- States:
  - SCAN: dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle, a valid `rs` latches pattern P, freezes c, and moves to DEBOUNCE. Otherwise c advances (3 wraps to 0) and the dwell counter resets.
  - DEBOUNCE: column held. Each cycle `rs`==P increments the counter. Any mismatch returns to SCAN with the counter cleared and c advanced. When the counter reaches DEBOUNCE_CNT, move to ACCEPT.
  - ACCEPT (one cycle): `out` <= {out[3:0], digit}, `key_code` <= digit, `key_valid` <= 1. Move to RELEASE.
  - RELEASE: column held. The counter increments while `rs`==4'hF and clears on any low bit. When it reaches DEBOUNCE_CNT, go to SCAN, c advances.
- A key held indefinitely produces exactly one `key_valid`. A bounce during release produces none.
- No other input modifies `out`. Only `clr` clears it.

## Timing
- Synchroniser latency: 2 cycles from a `KEY_R` change to `rs`.
- Press latency: the press is detected on the sampling cycle of its own column. `key_valid` rises DEBOUNCE_CNT+1 cycles after detection. `out` and `key_code` become visible in the same cycle as `key_valid` (registered outputs).
- `key_valid` is high for exactly 1 cycle and never in two consecutive cycles.
- Full scan period: 4*SCAN_DIV cycles with no key pressed.
- `clr` asserted at any time, including mid-DEBOUNCE or mid-RELEASE: all outputs return to reset values asynchronously and no pulse is emitted. After deassertion, a still-held key is re-detected and accepted once.

## Structure
- Package `key_pkg`: state enum (SCAN, DEBOUNCE, ACCEPT, RELEASE), the `COL_IDLE`=4'b1110 constant, and the function mapping (r,c) to digit.
- One sub-module, `key_sync`: a 2-flop synchroniser, 4 bits wide, reset to 4'hF. The FSM, counters and entry register stay in `key_scanner`.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_CNT=8.
- Reset, no key: `KEY_C` cycles 1110→1101→1011→0111→1110, 4 cycles each. `out`=00. `key_valid` never rises.
- Key r=1,c=2 held 200 cycles, then released: exactly one `key_valid`. `key_code`=6, `out`=8'h06. Scanning resumes after release debounce.
- Keys r=3,c=3 then r=0,c=1 pressed in sequence: `out`=8'h0F, then 8'hF1. The third key r=2,c=0 gives `out`=8'h18.
- Row toggles every 3 cycles during DEBOUNCE: no `key_valid`, FSM returns to SCAN. A stable press afterwards is accepted once.
- Rows 1 and 2 low together on column 0: no `key_valid`, scanning continues uninterrupted.
- `clr` pulsed low during RELEASE after `out`=8'h06: `out`=00 immediately. Key still held after `clr` rises: one new pulse, `out`=8'h06.
